mir_sequencer: RTL and testbench

Microprogram sequencer for the microcoded datapath: owns the microprogram counter (MPC) and a registered microinstruction register (MIR). It fetches from an external asynchronous-read control store and slices the registered word into datapath control fields. It evaluates the COND field against ALU flags and IR bit 13 to choose the next address: next, branch, decode or trap. Adds stall-hold, trap vectoring and a fetch-valid flag to the plain field-slicing register.

---
 rtl/mir_pkg.sv | 47 ++++
 rtl/mir_sequencer_if.sv | 44 ++++
 rtl/mir_next_addr.sv | 45 ++++
 rtl/mir_sequencer.sv | 65 ++++++
 tb/tb_mir_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mir_pkg.sv
// Shared definitions for the microprogram sequencer: field widths, microword
// layout offsets, condition encodings and the decode-address formatter.
package mir_pkg;

    localparam int REG_BUS_WIDTH       = 6;
    localparam int ALU_BUS_WIDTH       = 4;
    localparam int COND_BUS_WIDTH      = 3;
    localparam int JUMP_ADDR_BUS_WIDTH = 11;
    localparam int MIR_BUS_WIDTH       = 3*REG_BUS_WIDTH + ALU_BUS_WIDTH + COND_BUS_WIDTH
                                         + JUMP_ADDR_BUS_WIDTH + 5;

    localparam logic [JUMP_ADDR_BUS_WIDTH-1:0] TRAP_VECTOR_DEFAULT = 11'h7F0;

    // Microword layout, MSB to LSB: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, JUMP_ADDR
    localparam int JUMP_LSB = 0;
    localparam int COND_LSB = JUMP_LSB + JUMP_ADDR_BUS_WIDTH;
    localparam int ALU_LSB  = COND_LSB + COND_BUS_WIDTH;
    localparam int WR_BIT   = ALU_LSB + ALU_BUS_WIDTH;
    localparam int RD_BIT   = WR_BIT + 1;
    localparam int CMUX_BIT = RD_BIT + 1;
    localparam int C_LSB    = CMUX_BIT + 1;
    localparam int BMUX_BIT = C_LSB + REG_BUS_WIDTH;
    localparam int B_LSB    = BMUX_BIT + 1;
    localparam int AMUX_BIT = B_LSB + REG_BUS_WIDTH;
    localparam int A_LSB    = AMUX_BIT + 1;

    typedef enum logic [COND_BUS_WIDTH-1:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    // Dispatch address {1, op, op3, 00}, zero-extended to the microaddress width
    function automatic logic [JUMP_ADDR_BUS_WIDTH-1:0] decode_addr(input logic [1:0] op,
                                                                   input logic [5:0] op3);
        logic [JUMP_ADDR_BUS_WIDTH-1:0] addr;
        addr       = '0;
        addr[10:0] = {1'b1, op, op3, 2'b00};
        return addr;
    endfunction

endpackage

// File: rtl/mir_sequencer_if.sv
// Datapath-facing bundle of the sequencer: control inputs, control-store port
// and the sliced microinstruction fields.
interface mir_sequencer_if;
    import mir_pkg::*;

    logic                           MIRSEQ_STALL_InHigh;
    logic                           MIRSEQ_TRAP_InHigh;
    logic [3:0]                     MIRSEQ_FLAGS_IN;
    logic [31:0]                    MIRSEQ_IR_IN;
    logic [MIR_BUS_WIDTH-1:0]       MIRSEQ_ROM_DATA_IN;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] MIRSEQ_ROM_ADDR_OUT;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] MIRSEQ_MPC_OUT;
    logic                           MIRSEQ_VALID_OUT;
    logic [REG_BUS_WIDTH-1:0]       MIRSEQ_A_OUT;
    logic [REG_BUS_WIDTH-1:0]       MIRSEQ_B_OUT;
    logic [REG_BUS_WIDTH-1:0]       MIRSEQ_C_OUT;
    logic                           MIRSEQ_AMUX_OUT;
    logic                           MIRSEQ_BMUX_OUT;
    logic                           MIRSEQ_CMUX_OUT;
    logic                           MIRSEQ_RD_OUT;
    logic                           MIRSEQ_WR_OUT;
    logic [ALU_BUS_WIDTH-1:0]       MIRSEQ_ALU_OUT;
    logic [COND_BUS_WIDTH-1:0]      MIRSEQ_COND_OUT;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] MIRSEQ_JUMP_ADDR_OUT;

    modport master (
        output MIRSEQ_STALL_InHigh, MIRSEQ_TRAP_InHigh, MIRSEQ_FLAGS_IN, MIRSEQ_IR_IN,
               MIRSEQ_ROM_DATA_IN,
        input  MIRSEQ_ROM_ADDR_OUT, MIRSEQ_MPC_OUT, MIRSEQ_VALID_OUT,
               MIRSEQ_A_OUT, MIRSEQ_B_OUT, MIRSEQ_C_OUT,
               MIRSEQ_AMUX_OUT, MIRSEQ_BMUX_OUT, MIRSEQ_CMUX_OUT, MIRSEQ_RD_OUT, MIRSEQ_WR_OUT,
               MIRSEQ_ALU_OUT, MIRSEQ_COND_OUT, MIRSEQ_JUMP_ADDR_OUT
    );

    modport slave (
        input  MIRSEQ_STALL_InHigh, MIRSEQ_TRAP_InHigh, MIRSEQ_FLAGS_IN, MIRSEQ_IR_IN,
               MIRSEQ_ROM_DATA_IN,
        output MIRSEQ_ROM_ADDR_OUT, MIRSEQ_MPC_OUT, MIRSEQ_VALID_OUT,
               MIRSEQ_A_OUT, MIRSEQ_B_OUT, MIRSEQ_C_OUT,
               MIRSEQ_AMUX_OUT, MIRSEQ_BMUX_OUT, MIRSEQ_CMUX_OUT, MIRSEQ_RD_OUT, MIRSEQ_WR_OUT,
               MIRSEQ_ALU_OUT, MIRSEQ_COND_OUT, MIRSEQ_JUMP_ADDR_OUT
    );

endinterface

// File: rtl/mir_next_addr.sv
// Combinational next-microaddress selection: reset/bubble, stall hold, trap,
// then condition evaluation, decode dispatch or increment.
module mir_next_addr
    import mir_pkg::*;
#(
    parameter logic [JUMP_ADDR_BUS_WIDTH-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic                           rst,
    input  logic                           valid,
    input  logic                           stall,
    input  logic                           trap,
    input  logic [JUMP_ADDR_BUS_WIDTH-1:0] mpc,
    input  cond_e                          cond,
    input  logic [JUMP_ADDR_BUS_WIDTH-1:0] jump,
    input  logic [3:0]                     flags,
    input  logic [1:0]                     ir_op,
    input  logic [5:0]                     ir_op3,
    input  logic                           ir_b13,
    output logic [JUMP_ADDR_BUS_WIDTH-1:0] next
);

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_N:    taken = flags[3];
            COND_Z:    taken = flags[2];
            COND_V:    taken = flags[1];
            COND_C:    taken = flags[0];
            COND_IR13: taken = ir_b13;
            COND_JUMP: taken = 1'b1;
            default:   taken = 1'b0;
        endcase

        // An empty MIR always refetches address 0, even while stalled
        if (rst || !valid)              next = '0;
        else if (stall)                 next = mpc;
        else if (trap)                  next = TRAP_VECTOR;
        else if (cond == COND_DECODE)   next = decode_addr(ir_op, ir_op3);
        else if (taken)                 next = jump;
        else                            next = mpc + 1'b1;
    end

endmodule

// File: rtl/mir_sequencer.sv
// Microprogram sequencer: MPC/MIR/VALID registers, control-store fetch and
// slicing of the registered microword into datapath control fields.
module mir_sequencer
    import mir_pkg::*;
#(
    parameter logic [JUMP_ADDR_BUS_WIDTH-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic          MIRSEQ_CLOCK_50,
    input  logic          MIRSEQ_RESET_InHigh,
    mir_sequencer_if.slave bus
);

    logic [JUMP_ADDR_BUS_WIDTH-1:0] mpc;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] next;
    logic [MIR_BUS_WIDTH-1:0]       mir;
    logic                           valid;
    logic [31:0]                    ir;
    logic                           unused_ir;

    assign ir        = bus.MIRSEQ_IR_IN;
    assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

    mir_next_addr #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_addr (
        .rst    (MIRSEQ_RESET_InHigh),
        .valid  (valid),
        .stall  (bus.MIRSEQ_STALL_InHigh),
        .trap   (bus.MIRSEQ_TRAP_InHigh),
        .mpc    (mpc),
        .cond   (cond_e'(mir[COND_LSB +: COND_BUS_WIDTH])),
        .jump   (mir[JUMP_LSB +: JUMP_ADDR_BUS_WIDTH]),
        .flags  (bus.MIRSEQ_FLAGS_IN),
        .ir_op  (ir[31:30]),
        .ir_op3 (ir[24:19]),
        .ir_b13 (ir[13]),
        .next   (next)
    );

    always_ff @(posedge MIRSEQ_CLOCK_50) begin
        if (MIRSEQ_RESET_InHigh) begin
            mpc   <= '0;
            mir   <= '0;
            valid <= 1'b0;
        end else if (!bus.MIRSEQ_STALL_InHigh) begin
            mpc   <= next;
            mir   <= bus.MIRSEQ_ROM_DATA_IN;
            valid <= 1'b1;
        end
    end

    assign bus.MIRSEQ_ROM_ADDR_OUT  = next;
    assign bus.MIRSEQ_MPC_OUT       = mpc;
    assign bus.MIRSEQ_VALID_OUT     = valid;
    assign bus.MIRSEQ_A_OUT         = mir[A_LSB +: REG_BUS_WIDTH];
    assign bus.MIRSEQ_AMUX_OUT      = mir[AMUX_BIT];
    assign bus.MIRSEQ_B_OUT         = mir[B_LSB +: REG_BUS_WIDTH];
    assign bus.MIRSEQ_BMUX_OUT      = mir[BMUX_BIT];
    assign bus.MIRSEQ_C_OUT         = mir[C_LSB +: REG_BUS_WIDTH];
    assign bus.MIRSEQ_CMUX_OUT      = mir[CMUX_BIT];
    assign bus.MIRSEQ_RD_OUT        = mir[RD_BIT];
    assign bus.MIRSEQ_WR_OUT        = mir[WR_BIT];
    assign bus.MIRSEQ_ALU_OUT       = mir[ALU_LSB +: ALU_BUS_WIDTH];
    assign bus.MIRSEQ_COND_OUT      = mir[COND_LSB +: COND_BUS_WIDTH];
    assign bus.MIRSEQ_JUMP_ADDR_OUT = mir[JUMP_LSB +: JUMP_ADDR_BUS_WIDTH];

endmodule

// File: tb/tb_mir_sequencer.sv
// Bench for mir_sequencer: a small control store program walked cycle by cycle
// from a vector table, with expected post-edge state queued and checked.
module tb_mir_sequencer;
    import mir_pkg::*;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        trap;
        logic [3:0]  flags;
        logic [31:0] ir;
        logic [10:0] addr;   // required ROM_ADDR_OUT before the edge
        logic [10:0] mpc;    // required MPC after the edge
        logic        valid;  // required VALID after the edge
    } vec_t;

    typedef struct {
        logic [10:0] mpc;
        logic        valid;
        logic [40:0] word;
    } exp_t;

    logic clk;
    logic rst;
    logic [40:0] rom [2048];
    exp_t sb[$];
    int checks;
    int errors;
    vec_t vecs[25];

    mir_sequencer_if bus();

    mir_sequencer dut (
        .MIRSEQ_CLOCK_50     (clk),
        .MIRSEQ_RESET_InHigh (rst),
        .bus                 (bus)
    );

    assign bus.MIRSEQ_ROM_DATA_IN = rom[bus.MIRSEQ_ROM_ADDR_OUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [40:0] mw(input logic [5:0] a, input logic amux, input logic [5:0] b,
                                       input logic bmux, input logic [5:0] c, input logic cmux,
                                       input logic rd, input logic wr, input logic [3:0] alu,
                                       input logic [2:0] cond, input logic [10:0] jump);
        return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, jump};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic t, input logic [3:0] f,
                                input logic [31:0] i, input logic [10:0] ad, input logic [10:0] m,
                                input logic v);
        vec_t x;
        x.rst = r; x.stall = s; x.trap = t; x.flags = f; x.ir = i;
        x.addr = ad; x.mpc = m; x.valid = v;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        logic [40:0] got;
        @(negedge clk);
        rst                     = v.rst;
        bus.MIRSEQ_STALL_InHigh = v.stall;
        bus.MIRSEQ_TRAP_InHigh  = v.trap;
        bus.MIRSEQ_FLAGS_IN     = v.flags;
        bus.MIRSEQ_IR_IN        = v.ir;
        #1;
        chk($sformatf("step%0d rom_addr", idx), 64'(bus.MIRSEQ_ROM_ADDR_OUT), 64'(v.addr));
        e.mpc   = v.mpc;
        e.valid = v.valid;
        e.word  = v.valid ? rom[v.mpc] : 41'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("step%0d scoreboard", idx), 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            got = {bus.MIRSEQ_A_OUT, bus.MIRSEQ_AMUX_OUT, bus.MIRSEQ_B_OUT, bus.MIRSEQ_BMUX_OUT,
                   bus.MIRSEQ_C_OUT, bus.MIRSEQ_CMUX_OUT, bus.MIRSEQ_RD_OUT, bus.MIRSEQ_WR_OUT,
                   bus.MIRSEQ_ALU_OUT, bus.MIRSEQ_COND_OUT, bus.MIRSEQ_JUMP_ADDR_OUT};
            chk($sformatf("step%0d mpc", idx), 64'(bus.MIRSEQ_MPC_OUT), 64'(e.mpc));
            chk($sformatf("step%0d valid", idx), 64'(bus.MIRSEQ_VALID_OUT), 64'(e.valid));
            chk($sformatf("step%0d fields", idx), 64'(got), 64'(e.word));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.MIRSEQ_STALL_InHigh = 1'b0;
        bus.MIRSEQ_TRAP_InHigh  = 1'b0;
        bus.MIRSEQ_FLAGS_IN     = 4'h0;
        bus.MIRSEQ_IR_IN        = 32'h0;
        for (int i = 0; i < 2048; i++) rom[i] = '0;

        // Control store program: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, JUMP
        rom[11'h000] = mw(6'd5,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 11'h000);
        rom[11'h001] = mw(6'd1,  1'b0, 6'd2,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'h1, 3'b010, 11'h040);
        rom[11'h002] = mw(6'd0,  1'b1, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'h2, 3'b001, 11'h050);
        rom[11'h040] = mw(6'd7,  1'b1, 6'd9,  1'b0, 6'd3,  1'b0, 1'b1, 1'b0, 4'hA, 3'b000, 11'h123);
        rom[11'h041] = mw(6'd2,  1'b0, 6'd4,  1'b1, 6'd6,  1'b0, 1'b0, 1'b1, 4'h3, 3'b111, 11'h000);
        rom[11'h050] = mw(6'd0,  1'b0, 6'd0,  1'b0, 6'd8,  1'b1, 1'b0, 1'b0, 4'h4, 3'b011, 11'h060);
        rom[11'h051] = mw(6'd11, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'h5, 3'b100, 11'h070);
        rom[11'h070] = mw(6'd0,  1'b0, 6'd12, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 4'h6, 3'b101, 11'h080);
        rom[11'h080] = mw(6'd13, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'h7, 3'b101, 11'h090);
        rom[11'h604] = mw(6'd20, 1'b0, 6'd21, 1'b0, 6'd22, 1'b0, 1'b0, 1'b0, 4'h8, 3'b110, 11'h100);
        rom[11'h7F0] = mw(6'd30, 1'b1, 6'd31, 1'b1, 6'd32, 1'b1, 1'b0, 1'b0, 4'h9, 3'b110, 11'h7FF);
        rom[11'h7FF] = mw(6'd63, 1'b1, 6'd63, 1'b1, 6'd63, 1'b1, 1'b1, 1'b1, 4'hF, 3'b000, 11'h7FF);

        //              rst   stall trap  flags   ir             addr     mpc      valid
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         11'h000, 11'h000, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h000, 11'h000, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h001, 11'h001, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 4'b0100, 32'h0,      11'h040, 11'h040, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h0,         11'h040, 11'h040, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF,  11'h040, 11'h040, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 4'h0, 32'h0,         11'h040, 11'h040, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h041, 11'h041, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h80080000,  11'h604, 11'h604, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'h0, 32'h0,         11'h7F0, 11'h7F0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h7FF, 11'h7FF, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h000, 11'h000, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h001, 11'h001, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 4'b1011, 32'h0,      11'h002, 11'h002, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 4'b1000, 32'h0,      11'h050, 11'h050, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 4'b1101, 32'h0,      11'h051, 11'h051, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 4'b0001, 32'h0,      11'h070, 11'h070, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h00002000,  11'h080, 11'h080, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFFDFFF,  11'h081, 11'h081, 1'b1);
        vecs[19] = mk(1'b1, 1'b1, 1'b1, 4'hF, 32'h0,         11'h000, 11'h000, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 1'b0, 4'h0, 32'h0,         11'h000, 11'h000, 1'b0);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h000, 11'h000, 1'b1);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h001, 11'h001, 1'b1);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 4'b0100, 32'h0,      11'h040, 11'h040, 1'b1);
        vecs[24] = mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         11'h041, 11'h041, 1'b1);

        foreach (vecs[i]) step(vecs[i], i);

        // Trap held through a stall is honoured only once the stall drops
        step(mk(1'b0, 1'b1, 1'b1, 4'h0, 32'h0, 11'h041, 11'h041, 1'b1), 100);
        step(mk(1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 11'h7F0, 11'h7F0, 1'b1), 101);
        // Reset in the middle of a program, then resume from address 0
        step(mk(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 11'h000, 11'h000, 1'b0), 102);
        step(mk(1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 11'h000, 11'h000, 1'b1), 103);
        step(mk(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 11'h001, 11'h001, 1'b1), 104);

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
